spi_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares the single SoC SPI master byte engine between `NUM_REQ` requesters, such as the CPU-side SPI register block and a pixel-matrix configuration engine. It grants one requester at a time for a whole burst and owns slave-select timing (setup, hold, inter-burst gap). It issues byte starts to the engine and routes received bytes back to the burst owner. It aborts stalled bursts with a timeout.

---
 rtl/spi_arbiter_if.sv | 32 +++
 rtl/spi_arbiter.sv | 114 +++++++++++
 tb/tb_spi_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Bundle between the SPI arbiter, its requesters and the shared SPI byte engine.
// The arbiter side uses modport master; requesters/engine (or a bench) use slave.
interface spi_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   last;
  logic [8*NUM_REQ-1:0] tx_data;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           rx_data;
  logic [NUM_REQ-1:0]   rx_valid;
  logic [NUM_REQ-1:0]   err;
  logic [OW-1:0]        owner;
  logic                 busy;
  logic                 ss_n;
  logic                 spi_start;
  logic [7:0]           spi_tx_data;
  logic                 spi_done;
  logic [7:0]           spi_rx_data;

  modport master (
    input  req, last, tx_data, spi_done, spi_rx_data,
    output ack, rx_data, rx_valid, err, owner, busy, ss_n, spi_start, spi_tx_data
  );

  modport slave (
    output req, last, tx_data, spi_done, spi_rx_data,
    input  ack, rx_data, rx_valid, err, owner, busy, ss_n, spi_start, spi_tx_data
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin burst arbiter in front of one SPI byte engine; owns slave-select
// setup/hold/gap timing and aborts bursts whose owner stalls between bytes.
module spi_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int CS_GAP       = 4,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_arbiter_if.master bus
);
  localparam int OW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int M0   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int M1   = (CS_GAP > IDLE_TIMEOUT) ? CS_GAP : IDLE_TIMEOUT;
  localparam int CMAX = (M0 > M1) ? M0 : M1;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, XFER, HOLD, GAP} state_t;

  state_t        r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_rr;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_ss_n;

  logic [NUM_REQ-1:0] w_onehot;
  logic [CW-1:0]      w_cnt_inc;
  logic               w_req_own;
  logic               w_issue;
  logic               w_abort;
  logic               w_done;
  logic               w_found;
  logic [OW-1:0]      w_pick;
  logic [OW-1:0]      w_k;

  assign w_onehot  = NUM_REQ'(1) << r_owner;
  assign w_cnt_inc = (r_cnt == CW'(CMAX)) ? r_cnt : r_cnt + 1'b1;
  assign w_req_own = bus.req[r_owner];
  assign w_issue   = (r_state == ISSUE) && w_req_own;
  assign w_abort   = (r_state == ISSUE) && !w_req_own && (r_cnt == CW'(IDLE_TIMEOUT - 1));
  assign w_done    = (r_state == XFER) && bus.spi_done;

  // First pending request at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = OW'((int'(r_rr) + i) % NUM_REQ);
      if (!w_found && bus.req[w_k]) begin
        w_found = 1'b1;
        w_pick  = w_k;
      end
    end
  end

  assign bus.ack         = w_issue ? w_onehot : '0;
  assign bus.spi_start   = w_issue;
  assign bus.spi_tx_data = w_issue ? bus.tx_data[{r_owner, 3'b000} +: 8] : 8'h00;
  assign bus.rx_valid    = w_done ? w_onehot : '0;
  assign bus.rx_data     = w_done ? bus.spi_rx_data : 8'h00;
  assign bus.err         = w_abort ? w_onehot : '0;
  assign bus.owner       = r_owner;
  assign bus.busy        = (r_state != IDLE);
  assign bus.ss_n        = r_ss_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_ss_n  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_owner <= w_pick;
          r_ss_n  <= 1'b0;
          r_cnt   <= '0;
          r_state <= SETUP;
        end
        SETUP: if (r_cnt == CW'(CS_SETUP - 1)) begin
          r_cnt   <= '0;
          r_state <= ISSUE;
        end else r_cnt <= w_cnt_inc;
        // The counter doubles as the stall timer while waiting for the owner.
        ISSUE: if (w_issue) begin
          r_last  <= bus.last[r_owner];
          r_cnt   <= '0;
          r_state <= XFER;
        end else if (w_abort) begin
          r_cnt   <= '0;
          r_state <= HOLD;
        end else r_cnt <= w_cnt_inc;
        XFER: if (bus.spi_done) r_state <= r_last ? HOLD : ISSUE;
        HOLD: if (r_cnt == CW'(CS_HOLD - 1)) begin
          r_ss_n  <= 1'b1;
          r_cnt   <= '0;
          r_state <= GAP;
        end else r_cnt <= w_cnt_inc;
        GAP: if (r_cnt == CW'(CS_GAP - 1)) begin
          r_rr    <= (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end else r_cnt <= w_cnt_inc;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: single and multi-byte bursts, stray done,
// reset mid-burst, two-way contention and stall abort.
module tb_spi_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  spi_arbiter_if #(.NUM_REQ(2)) bus ();

  spi_arbiter #(
    .NUM_REQ(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4), .IDLE_TIMEOUT(256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    int hi;
    int exp_own;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.last = '0;
    bus.tx_data = '0;
    bus.spi_done = 1'b0;
    bus.spi_rx_data = '0;

    // reset values, with a stray engine done
    nxt();
    bus.spi_done = 1'b1;
    smp();
    chk("rst_ss_n", bus.ss_n, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_pulses", {bus.ack, bus.rx_valid, bus.err, bus.spi_start}, 0);
    chk("rst_data", {bus.spi_tx_data, bus.rx_data}, 0);
    nxt();
    bus.spi_done = 1'b0;
    rst_n = 1'b1;
    nxt(2);

    // single one-byte burst, cycle 0 = req
    bus.req = 2'b01; bus.last = 2'b01; bus.tx_data = 16'h00A5;
    nxt();
    smp(); chk("t1_ss_c1", bus.ss_n, 0);
    chk("t1_busy_c1", bus.busy, 1);
    nxt();
    smp(); chk("t1_nostart_c2", bus.spi_start, 0);
    nxt();
    smp(); chk("t1_start_c3", bus.spi_start, 1);
    chk("t1_ack_c3", bus.ack, 2'b01);
    chk("t1_txd_c3", bus.spi_tx_data, 8'hA5);
    nxt();
    bus.req = 2'b00;
    nxt(6);
    bus.spi_done = 1'b1; bus.spi_rx_data = 8'h3C;
    smp(); chk("t1_rxv_c10", bus.rx_valid, 2'b01);
    chk("t1_rxd_c10", bus.rx_data, 8'h3C);
    nxt();
    bus.spi_done = 1'b0;
    smp(); chk("t1_ss_c11", bus.ss_n, 0);
    nxt();
    smp(); chk("t1_ss_c12", bus.ss_n, 0);
    nxt();
    smp(); chk("t1_ss_c13", bus.ss_n, 1);
    nxt(4);
    smp(); chk("t1_idle_c17", bus.busy, 0);

    // three-byte burst from req0 (rr pointer now 1, search wraps to 0)
    bus.req = 2'b01; bus.last = 2'b00; bus.tx_data = 16'h0001;
    nxt(3);
    smp(); chk("t2_start1", bus.spi_start, 1);
    chk("t2_txd1", bus.spi_tx_data, 8'h01);
    chk("t2_ack1", bus.ack, 2'b01);
    nxt();
    bus.tx_data = 16'h0002;
    nxt(2);
    bus.spi_done = 1'b1; bus.spi_rx_data = 8'hB1;
    smp(); chk("t2_rxd1", bus.rx_data, 8'hB1);
    nxt();
    bus.spi_done = 1'b0;
    smp(); chk("t2_start2", bus.spi_start, 1);
    chk("t2_txd2", bus.spi_tx_data, 8'h02);
    chk("t2_ss2", bus.ss_n, 0);
    nxt();
    bus.tx_data = 16'h0003; bus.last = 2'b01;
    nxt();
    bus.spi_done = 1'b1; bus.spi_rx_data = 8'hB2;
    nxt();
    bus.spi_done = 1'b0;
    smp(); chk("t2_start3", bus.spi_start, 1);
    chk("t2_txd3", bus.spi_tx_data, 8'h03);
    chk("t2_ss3", bus.ss_n, 0);
    nxt();
    bus.req = 2'b00;
    nxt();
    bus.spi_done = 1'b1; bus.spi_rx_data = 8'hB3;
    smp(); chk("t2_rxv3", bus.rx_valid, 2'b01);
    nxt();
    bus.spi_done = 1'b0;
    nxt();
    smp(); chk("t2_ss_hold", bus.ss_n, 0);
    nxt();
    smp(); chk("t2_ss_rise", bus.ss_n, 1);
    nxt();
    bus.spi_done = 1'b1;
    smp(); chk("stray_gap_rxv", bus.rx_valid, 0);
    nxt();
    bus.spi_done = 1'b0;
    nxt(2);
    bus.spi_done = 1'b1;
    smp(); chk("stray_idle_rxv", bus.rx_valid, 0);
    chk("stray_idle_busy", bus.busy, 0);
    nxt();
    bus.spi_done = 1'b0;

    // reset during XFER; the engine completes its byte while in reset
    bus.req = 2'b01; bus.last = 2'b01; bus.tx_data = 16'h005A;
    nxt(4);
    bus.req = 2'b00;
    nxt();
    rst_n = 1'b0;
    bus.spi_done = 1'b1;
    smp(); chk("rstmid_ss_n", bus.ss_n, 1);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_rxv", bus.rx_valid, 0);
    nxt();
    bus.spi_done = 1'b0;
    bus.req = 2'b11; bus.last = 2'b11; bus.tx_data = 16'hB1A0;
    nxt();
    rst_n = 1'b1;

    // contention: grants alternate 0,1,0,1
    for (int b = 0; b < 4; b++) begin
      exp_own = b % 2;
      hi = 0; k = 0;
      smp();
      while (bus.spi_start !== 1'b1 && k < 60) begin
        if (bus.ss_n === 1'b1) hi++;
        nxt(); smp(); k++;
      end
      chk($sformatf("c%0d_start_seen", b), k < 60, 1);
      if (b > 0) chk($sformatf("c%0d_gap", b), hi, 5);
      chk($sformatf("c%0d_owner", b), bus.owner, exp_own);
      chk($sformatf("c%0d_ack", b), bus.ack, (exp_own == 0) ? 2'b01 : 2'b10);
      chk($sformatf("c%0d_txd", b), bus.spi_tx_data, (exp_own == 0) ? 8'hA0 : 8'hB1);
      nxt();
      if (b == 3) bus.req = 2'b00;
      bus.spi_done = 1'b1; bus.spi_rx_data = 8'(8'h50 + b);
      smp(); chk($sformatf("c%0d_rxv", b), bus.rx_valid, (exp_own == 0) ? 2'b01 : 2'b10);
      nxt();
      bus.spi_done = 1'b0;
    end
    k = 0;
    smp();
    while (bus.busy !== 1'b0 && k < 60) begin nxt(); smp(); k++; end
    chk("c_idle_seen", k < 60, 1);

    // stall abort on requester 1
    nxt();
    bus.req = 2'b10; bus.last = 2'b00; bus.tx_data = 16'h1100;
    k = 0;
    smp();
    while (bus.spi_start !== 1'b1 && k < 60) begin nxt(); smp(); k++; end
    chk("s_start_seen", k < 60, 1);
    chk("s_ack", bus.ack, 2'b10);
    chk("s_txd", bus.spi_tx_data, 8'h11);
    nxt();
    bus.req = 2'b00;
    nxt();
    bus.spi_done = 1'b1; bus.spi_rx_data = 8'h22;
    smp(); chk("s_rxv", bus.rx_valid, 2'b10);
    nxt();
    bus.spi_done = 1'b0;
    k = 0;
    smp();
    while (bus.err === 2'b00 && k < 400) begin nxt(); smp(); k++; end
    chk("s_err_time", k, 255);
    chk("s_err_who", bus.err, 2'b10);
    nxt();
    smp(); chk("s_err_once", bus.err, 0);
    chk("s_ss_h1", bus.ss_n, 0);
    nxt();
    smp(); chk("s_ss_h2", bus.ss_n, 0);
    nxt();
    smp(); chk("s_ss_rise", bus.ss_n, 1);
    k = 0;
    while (bus.busy !== 1'b0 && k < 60) begin nxt(); smp(); k++; end
    chk("s_idle_seen", k < 60, 1);

    // pointer advanced to 0: both requesting, 0 wins
    nxt();
    bus.req = 2'b11; bus.last = 2'b11; bus.tx_data = 16'hB1A0;
    k = 0;
    smp();
    while (bus.spi_start !== 1'b1 && k < 60) begin nxt(); smp(); k++; end
    chk("rr_start_seen", k < 60, 1);
    chk("rr_owner", bus.owner, 0);
    chk("rr_ack", bus.ack, 2'b01);
    nxt();
    bus.req = 2'b00;
    bus.spi_done = 1'b1;
    nxt();
    bus.spi_done = 1'b0;
    nxt(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
